// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the round-robin multiplier arbiter.
// Defaults here seed the parameters of the interface and the arbiter.
package mul_arb_pkg;

  localparam int MUL_NREQ  = 2;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_LAT   = 2;
  localparam int MUL_IDW   = 3;

  typedef logic [MUL_IDW-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } stage_t;

endpackage

// File: rtl/mul_rr_arbiter_if.sv
// Requester/response bus of the shared multiplier.
// Handshake: a request transfers on a rising edge where req_valid[i] and req_ready[i] are both high; rsp_valid is a one-cycle pulse with no backpressure.
interface mul_rr_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int NREQ  = MUL_NREQ,
  parameter int WIDTH = MUL_WIDTH,
  parameter int IDW   = MUL_IDW
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dataa;
  logic [NREQ*WIDTH-1:0] req_datab;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  busy;

  modport master (
    output req_valid, req_dataa, req_datab,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_dataa, req_datab,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface

// File: rtl/mul_pipe.sv
// Free-running multiplier: registered operands then LAT-1 product registers.
// No reset and no enable; validity is tracked alongside by the arbiter.
module mul_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] prod0;

  always_ff @(posedge clk) begin
    a_q <= dataa;
    b_q <= datab;
  end

  // WIDTH-wide context keeps only the low half of the product.
  assign prod0 = a_q * b_q;

  generate
    if (LAT == 1) begin : g_direct
      assign result = prod0;
    end else begin : g_stages
      logic [WIDTH-1:0] p_q [LAT-1];

      always_ff @(posedge clk) begin
        p_q[0] <= prod0;
        for (int s = 1; s < LAT - 1; s++) begin
          p_q[s] <= p_q[s-1];
        end
      end

      assign result = p_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
// Optional macro MUL_RR_ARBITER_STATS_EN adds per-requester saturating grant counters.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ  = MUL_NREQ,
  parameter int WIDTH = MUL_WIDTH,
  parameter int LAT   = MUL_LAT,
  parameter int IDW   = MUL_IDW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mul_rr_arbiter_if.slave        bus
`ifdef MUL_RR_ARBITER_STATS_EN
  ,
  output logic [NREQ*16-1:0]     stat_grants
`endif
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } entry_t;

  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] product;
  entry_t           stage [LAT];
  logic             busy_next;
  logic             busy_q;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    gnt_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_dataa[i*WIDTH +: WIDTH];
        sel_b = bus.req_datab[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (accept) begin
      ptr <= gnt_id;
    end
  end

  always_comb begin
    busy_next = accept;
    for (int s = 0; s < LAT - 1; s++) begin
      busy_next = busy_next | stage[s].valid;
    end
  end

  // Owner tags travel in lockstep with the multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        stage[s] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      stage[0] <= '{valid: accept, id: gnt_id};
      for (int s = 1; s < LAT; s++) begin
        stage[s] <= stage[s-1];
      end
      busy_q <= busy_next;
    end
  end

  mul_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_pipe (
    .clk    (clk),
    .dataa  (sel_a),
    .datab  (sel_b),
    .result (product)
  );

  // Datapath is unreset, so the result is masked outside valid slots.
  assign bus.rsp_valid  = stage[LAT-1].valid;
  assign bus.rsp_id     = stage[LAT-1].id;
  assign bus.rsp_result = stage[LAT-1].valid ? product : '0;
  assign bus.busy       = busy_q;

`ifdef MUL_RR_ARBITER_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && grant_cnt[i] != 16'hFFFF) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_grants[i*16 +: 16] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomized scoreboard bench for mul_rr_arbiter with a behavioural grant/product model.
// Stats counters are checked when MUL_RR_ARBITER_STATS_EN is defined.
module tb_mul_rr_arbiter;
  import mul_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int LAT   = 2;
  localparam int IDW   = 3;
  localparam int QW    = 32 + IDW + WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef MUL_RR_ARBITER_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
`endif

  mul_rr_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .IDW   (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUL_RR_ARBITER_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  // Scoreboard entry: {due cycle, owner id, expected result}
  logic [QW-1:0] exp_q[$];
  int model_last = NREQ - 1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Requester served is the first valid one after the previous winner, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[WIDTH-1:0];
  endfunction

  // Monitor + scoreboard: runs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [QW-1:0]   e;
        logic            due;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        check("busy", 64'(bus.busy), 64'(exp_q.size() > 0));
        due = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          due = (int'(e[QW-1 -: 32]) == cyc);
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(due));
        if (due) begin
          e = exp_q.pop_front();
          if (bus.rsp_valid) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(e[WIDTH+IDW-1:WIDTH]));
            check("rsp_result", 64'(bus.rsp_result), 64'(e[WIDTH-1:0]));
          end
        end
        while (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) < cyc) begin
          void'(exp_q.pop_front());
        end
        g = model_pick(bus.req_valid, model_last);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (g >= 0) begin
          exp_q.push_back({32'(cyc + LAT), IDW'(g),
                           model_mul(bus.req_dataa[g*WIDTH +: WIDTH], bus.req_datab[g*WIDTH +: WIDTH])});
          model_last = g;
        end
      end
    end
  end

  task automatic drive(input logic [NREQ-1:0] v,
                       input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                       input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    bus.req_valid = v;
    bus.req_dataa = {a1, a0};
    bus.req_datab = {b1, b0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, '0, '0);
  endtask

  // Asserts reset for one cycle from just after an edge and checks the cleared outputs.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    exp_q.delete();
    model_last = NREQ - 1;
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0001_0000;
      2:       return 32'(($urandom_range(0, 15)));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single requester, back-to-back
    drive(2'b01, 32'd1, 32'd2, 32'd0, 32'd0);
    drive(2'b01, 32'd332, 32'd22, 32'd0, 32'd0);
    drive(2'b01, 32'd2, 32'd23, 32'd0, 32'd0);
    idle(LAT + 2);

    // Contention from reset: grants alternate
    do_reset();
    drive(2'b11, 32'd3, 32'd5, 32'd7, 32'd9);
    drive(2'b11, 32'd3, 32'd5, 32'd7, 32'd9);
    drive(2'b11, 32'd11, 32'd13, 32'd17, 32'd19);
    drive(2'b11, 32'd11, 32'd13, 32'd17, 32'd19);
    drive(2'b11, 32'd100, 32'd100, 32'd7, 32'd9);
    drive(2'b11, 32'd100, 32'd100, 32'd7, 32'd9);
    idle(LAT + 2);

    // Truncation corners
    drive(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
    drive(2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2);
    drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    idle(LAT + 2);

    // Idle gap: isolated accepts five cycles apart
    drive(2'b01, 32'd6, 32'd7, 32'd0, 32'd0);
    idle(4);
    drive(2'b01, 32'd8, 32'd9, 32'd0, 32'd0);
    idle(LAT + 3);

    // Reset while a product is in flight
    drive(2'b01, 32'd3, 32'd4, 32'd0, 32'd0);
    do_reset();
    idle(LAT + 2);
    drive(2'b11, 32'd21, 32'd2, 32'd5, 32'd5);
    idle(LAT + 2);

    // Randomized traffic including dropped requests
    for (int i = 0; i < 400; i++) begin
      drive(NREQ'($urandom_range(0, 3)), rand_operand(), rand_operand(), rand_operand(), rand_operand());
    end
    idle(LAT + 2);

`ifdef MUL_RR_ARBITER_STATS_EN
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      drive(2'b01, 32'($urandom), 32'($urandom), 32'd0, 32'd0);
    end
    idle(LAT + 2);
    check("stat_req0", 64'(stat_grants[15:0]), 64'h0000_FFFF);
    check("stat_req1", 64'(stat_grants[31:16]), 64'd0);
`endif

    idle(LAT + 3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one pipelined 32-bit multiplier between NREQ requesters (e.g. Nios custom-instruction slots and a DMA-fed accumulator).
- Round-robin arbitration: accepts at most one operand pair per cycle, tracks the owner of every in-flight product through the pipeline, and returns each truncated result to its owner with a one-cycle valid pulse.
- Sits between the requesters and the multiplier datapath; the multiplier is an internal sub-module.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 32, operand and result width; result is the low WIDTH bits of the product.
- LAT, 2, multiplier pipeline depth in cycles (1..4).
- IDW, 3, width of requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has an operand pair pending.
- req_ready  out  NREQ  one-hot grant; the transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
- req_dataa  in  NREQ*WIDTH  operand A, slice i belongs to requester i.
- req_datab  in  NREQ*WIDTH  operand B, slice i belongs to requester i.
- rsp_valid  out  1  result valid, pulses for one cycle per accepted request.
- rsp_id  out  IDW  owner of rsp_result.
- rsp_result  out  WIDTH  low WIDTH bits of dataa*datab.
- busy  out  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, all stage valids=0, rr pointer=NREQ-1 so requester 0 has first priority.
- req_ready is combinational from req_valid and the rr pointer, never from req_data*.
- Search order is ptr+1, ptr+2, … wrapping modulo NREQ. The first requester in that order with req_valid high gets req_ready; all others are low. If no req_valid is high, req_ready is all 0.
- On an accepting edge, ptr is set to the granted index. With no accept, ptr holds.
- Throughput: one accept per cycle with no bubbles. The multiplier never stalls and responses have no backpressure, so requesters must always sink rsp.
- Latency: a request accepted at edge E produces rsp_valid high, with the matching rsp_id and rsp_result, during the cycle after edge E+LAT-1. This is exactly LAT cycles after the request cycle.
- Results come out strictly in acceptance order. Back-to-back accepts give back-to-back rsp pulses.
- Id tracking: a shift register of {valid, id}, LAT deep, moves in lockstep with the multiplier stages.
- Arithmetic is unsigned. The full 2*WIDTH product is truncated to the low WIDTH bits, with no overflow flag. Example: 0x0001_0000*0x0001_0000 gives 0.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… and no requester waits more than NREQ-1 cycles.
- A requester dropping req_valid without being granted is legal; nothing is recorded.
- Reset mid-operation discards all in-flight products. No rsp_valid occurs for them, even if rst_n deasserts within LAT cycles.
- busy equals the OR of the stage valid bits and is registered.

Optional Feature:
- Macro: MUL_RR_ARBITER_STATS_EN.
- When defined: extra output stat_grants (NREQ*16 bits), one 16-bit saturating grant counter per requester. Each counter increments on every accept for that requester, sticks at 0xFFFF, and is cleared by rst_n.
- When undefined: the port and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package mul_arb_pkg holds the default WIDTH/LAT/NREQ constants, the id typedef, and the stage-entry typedef {valid, id}.
- Sub-module mul_pipe (WIDTH, LAT): registered operand stage followed by LAT-1 product stages; no handshake and no reset on the data path.
- The arbiter owns the rr pointer, grant logic, id shift register and optional stats.

Test Plan:
- Single requester, NREQ=2, LAT=2: req0 sends (1,2) then (332,22) then (2,23) on consecutive cycles. Expect rsp_valid for 3 consecutive cycles with rsp_id=0 and results 2, 7304, 46, each appearing 2 cycles after its request cycle.
- Contention: req0 and req1 both valid continuously from reset. Grants alternate 0,1,0,1 and rsp_id alternates 0,1,0,1 with correct products, e.g. req1 (7,9) gives 63.
- Truncation: (0x0001_0000, 0x0001_0000) gives 0; (0xFFFF_FFFF, 2) gives 0xFFFF_FFFE.
- Idle gaps: accepts at cycles 0 and 5 give isolated one-cycle rsp_valid pulses at cycles 2 and 7. busy is low between the drained pulses.
- Reset mid-flight: accept (3,4), then assert rst_n low the next cycle for one cycle. No rsp_valid follows, busy=0, and after release req0 is granted first.
- With MUL_RR_ARBITER_STATS_EN: 70000 back-to-back accepts on req0 give stat_grants[15:0]=0xFFFF, and req1's counter is 0.
